// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, memory size codes,
// FSM state type and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // Offset of the last byte of an access (N-1) from the funct3 width field.
    function automatic logic [1:0] last_byte(input logic [1:0] w);
        case (w)
            2'b00:   last_byte = 2'd0;
            2'b01:   last_byte = 2'd1;
            default: last_byte = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] size_code(input logic [1:0] w);
        case (w)
            2'b00:   size_code = SZ_BYTE;
            2'b01:   size_code = SZ_HALF;
            default: size_code = SZ_WORD;
        endcase
    endfunction

    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        illegal_f3 = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave = the unit itself, master = execute/writeback stages plus memory.
interface lsu_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_err;
    logic [31:0]      resp_rdata;
    logic [TAG_W-1:0] resp_tag;

    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_size;
    logic [31:0]      mem_address;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag, mem_read_data,
        output req_ready, resp_valid, resp_err, resp_rdata, resp_tag,
        output mem_read, mem_write, mem_size, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag, mem_read_data,
        input  req_ready, resp_valid, resp_err, resp_rdata, resp_tag,
        input  mem_read, mem_write, mem_size, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data according to the load funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    // Select extension width and kind from funct3.
    always_comb begin
        data_o = 32'h0000_0000;
        case (funct3_i)
            F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
            F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
            F3_W:    data_o = data_i;
            F3_BU:   data_o = {24'h00_0000, data_i[7:0]};
            F3_HU:   data_o = {16'h0000, data_i[15:0]};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, misaligned accesses split into byte
// accesses. Define MISALIGN_TRAP_EN to reject misaligned requests instead.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned TAG_W     = 5
) (
    input logic clk,
    input logic rst,
    lsu_if.slave bus
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_e           state_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [31:0]      resp_rdata_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic [TAG_W-1:0] tag_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [1:0]       mem_size_q;
    logic [31:0]      mem_address_q;
    logic [31:0]      mem_write_data_q;
    logic             we_q;
    logic [2:0]       f3_q;

`ifndef MISALIGN_TRAP_EN
    logic             split_q;
    logic [1:0]       idx_q;
    logic [31:0]      addr_q;
    logic [23:0]      wdata_hi_q;
    logic [31:0]      asm_q;
    logic [1:0]       idx_nxt_s;
    logic [31:0]      nxt_wbyte_s;
`endif

    logic [1:0]       last_s;
    logic [32:0]      end_addr_s;
    logic             misalign_s;
    logic             reject_s;
    logic [31:0]      asm_s;
    logic [31:0]      ext_s;
    logic             last_beat_s;

    // Accept-time classification of the incoming request.
    always_comb begin
        last_s     = last_byte(bus.req_funct3[1:0]);
        end_addr_s = {1'b0, bus.req_addr} + {31'd0, last_s};
        misalign_s = (last_s & bus.req_addr[1:0]) != 2'b00;
        reject_s   = illegal_f3(bus.req_we, bus.req_funct3) || (end_addr_s >= MEM_LIMIT);
`ifdef MISALIGN_TRAP_EN
        reject_s   = reject_s || misalign_s;
`endif
    end

`ifdef MISALIGN_TRAP_EN
    // Every accepted access is a single native-width beat.
    always_comb begin
        asm_s       = bus.mem_read_data;
        last_beat_s = 1'b1;
    end
`else
    // Byte-lane assembly and next-beat store byte for the split path.
    always_comb begin
        asm_s       = asm_q;
        idx_nxt_s   = idx_q + 2'd1;
        last_beat_s = !split_q || (idx_q == last_byte(f3_q[1:0]));
        if (split_q) begin
            case (idx_q)
                2'd0:    asm_s[7:0]   = bus.mem_read_data[7:0];
                2'd1:    asm_s[15:8]  = bus.mem_read_data[7:0];
                2'd2:    asm_s[23:16] = bus.mem_read_data[7:0];
                2'd3:    asm_s[31:24] = bus.mem_read_data[7:0];
                default: asm_s        = asm_q;
            endcase
        end else begin
            asm_s = bus.mem_read_data;
        end
        case (idx_nxt_s)
            2'd1:    nxt_wbyte_s = {24'h00_0000, wdata_hi_q[7:0]};
            2'd2:    nxt_wbyte_s = {24'h00_0000, wdata_hi_q[15:8]};
            2'd3:    nxt_wbyte_s = {24'h00_0000, wdata_hi_q[23:16]};
            default: nxt_wbyte_s = 32'h0000_0000;
        endcase
    end
`endif

    lsu_extend u_extend (
        .data_i   (asm_s),
        .funct3_i (f3_q),
        .data_o   (ext_s)
    );

    // Control FSM; every output of the unit is a register written here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            req_ready_q      <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'h0000_0000;
            resp_tag_q       <= '0;
            tag_q            <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_size_q       <= SZ_BYTE;
            mem_address_q    <= 32'h0000_0000;
            mem_write_data_q <= 32'h0000_0000;
            we_q             <= 1'b0;
            f3_q             <= 3'b000;
`ifndef MISALIGN_TRAP_EN
            split_q          <= 1'b0;
            idx_q            <= 2'd0;
            addr_q           <= 32'h0000_0000;
            wdata_hi_q       <= 24'h00_0000;
            asm_q            <= 32'h0000_0000;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we;
                        f3_q        <= bus.req_funct3;
                        tag_q       <= bus.req_tag;
                        if (reject_s) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                            resp_tag_q   <= bus.req_tag;
                        end else begin
                            state_q       <= ACCESS;
                            mem_read_q    <= !bus.req_we;
                            mem_write_q   <= bus.req_we;
                            mem_address_q <= bus.req_addr;
`ifdef MISALIGN_TRAP_EN
                            mem_size_q       <= size_code(bus.req_funct3[1:0]);
                            mem_write_data_q <= bus.req_wdata;
`else
                            split_q    <= misalign_s;
                            idx_q      <= 2'd0;
                            addr_q     <= bus.req_addr;
                            wdata_hi_q <= bus.req_wdata[31:8];
                            asm_q      <= 32'h0000_0000;
                            mem_size_q <= misalign_s ? SZ_BYTE : size_code(bus.req_funct3[1:0]);
                            mem_write_data_q <= misalign_s ? {24'h00_0000, bus.req_wdata[7:0]}
                                                           : bus.req_wdata;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (last_beat_s) begin
                        state_q          <= DONE;
                        mem_read_q       <= 1'b0;
                        mem_write_q      <= 1'b0;
                        mem_size_q       <= SZ_BYTE;
                        mem_address_q    <= 32'h0000_0000;
                        mem_write_data_q <= 32'h0000_0000;
                        resp_valid_q     <= 1'b1;
                        resp_err_q       <= 1'b0;
                        resp_rdata_q     <= we_q ? 32'h0000_0000 : ext_s;
                        resp_tag_q       <= tag_q;
                    end else begin
`ifndef MISALIGN_TRAP_EN
                        idx_q            <= idx_nxt_s;
                        asm_q            <= asm_s;
                        mem_address_q    <= addr_q + {30'd0, idx_nxt_s};
                        mem_write_data_q <= nxt_wbyte_s;
`endif
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                    resp_tag_q   <= '0;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_tag       = resp_tag_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_size       = mem_size_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-abort
// sequence and randomized requests against a byte-array reference model.
module tb_load_store_unit;

    localparam int MEM_BYTES = 1024;

    logic clk;
    logic rst;
    logic mem_init;
    int   checks;
    int   failures;

    logic [7:0]  mem [0:MEM_BYTES-1];
    bit   [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [31:0] rd_data;

    lsu_if #(.TAG_W(5)) bus ();

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    // Data memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
            mem[16] <= 8'hEF; mem[17] <= 8'hBE; mem[18] <= 8'hAD; mem[19] <= 8'hDE;
            mem[1023] <= 8'h9C;
        end else if (bus.mem_write) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(bus.mem_size) && (bus.mem_address + 32'(i)) < 32'd1024)
                    mem[bus.mem_address[9:0] + 10'(i)] <= bus.mem_write_data[8*i +: 8];
        end
    end

    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(bus.mem_size) && (bus.mem_address + 32'(i)) < 32'd1024)
                rd_data[8*i +: 8] = mem[bus.mem_address[9:0] + 10'(i)];
    end
    assign bus.mem_read_data = rd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one request, applied to ref_mem.
    task automatic model_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wdata, output bit err, output bit [31:0] rdata,
                             output int lat, output int acc, output bit aligned);
        bit legal;
        longint unsigned last;
        int n, a;
        legal   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n       = 1 << f3[1:0];
        aligned = (addr % n) == 0;
        last    = {32'd0, addr} + longint'(n) - 64'd1;
        err     = !legal || (last >= 64'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
        if (!aligned) err = 1'b1;
`endif
        rdata = 32'h0;
        lat = 1;
        acc = 0;
        if (!err) begin
            lat = aligned ? 2 : 1 + n;
            acc = aligned ? 1 : n;
            a   = int'(addr);
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rdata |= 32'(ref_mem[a + i]) << (8 * i);
                if (!f3[2] && n < 4 && rdata[8*n-1]) rdata |= 32'hFFFF_FFFF << (8 * n);
            end
        end
    endtask

    // Issue one request and check every memory beat and the response.
    task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] wdata, input bit [4:0] tag,
                          output bit g_err, output bit [31:0] g_rdata, output int g_lat);
        bit m_err, m_al;
        bit [31:0] m_rd, mask, ewd;
        int m_lat, m_acc, acc, w;
        g_err = 1'b0; g_rdata = 32'h0; g_lat = 0;
        model_req(we, f3, addr, wdata, m_err, m_rd, m_lat, m_acc, m_al);
        w = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        if (!bus.req_ready) begin
            chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_tag = tag;
        acc = 0;
        for (int k = 1; k <= 12 && g_lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
                bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
            end
            if (bus.mem_read || bus.mem_write) begin
                chk("mem_dir", {30'd0, bus.mem_write, bus.mem_read}, {30'd0, we, !we});
                chk("mem_addr", bus.mem_address, m_al ? addr : addr + 32'(acc));
                chk("mem_size", 32'(bus.mem_size), m_al ? 32'(f3[1:0]) : 32'd0);
                if (we) begin
                    mask = !m_al ? 32'hFF : (f3[1:0] == 2'b00 ? 32'hFF :
                           (f3[1:0] == 2'b01 ? 32'hFFFF : 32'hFFFF_FFFF));
                    ewd  = m_al ? wdata : (wdata >> (8 * acc));
                    chk("mem_wdata", bus.mem_write_data & mask, ewd & mask);
                end
                acc++;
            end
            if (bus.resp_valid) begin
                g_lat = k; g_err = bus.resp_err; g_rdata = bus.resp_rdata;
                chk("resp_tag", 32'(bus.resp_tag), 32'(tag));
            end
        end
        if (g_lat == 0) chk("resp_timeout", 32'(bus.resp_valid), 32'd1);
        chk("resp_err", 32'(g_err), 32'(m_err));
        chk("resp_rdata", g_rdata, m_rd);
        chk("resp_latency", 32'(g_lat), 32'(m_lat));
        chk("access_beats", 32'(acc), 32'(m_acc));
        @(negedge clk);
        chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  tag;
        bit        e_err;
        bit [31:0] e_rdata;
        int        e_lat;
    } vec_t;

    vec_t tv [17];

    initial begin
        bit g_err;
        bit [31:0] g_rd;
        int g_lat, diffs;
        checks = 0; failures = 0;
        rst = 1'b0; mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_tag = 5'd0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;
        ref_mem[1023] = 8'h9C;

        #2 rst = 1'b1;
        #1;
        chk("reset_ctrl", {20'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read,
                           bus.mem_write, bus.mem_size, bus.resp_tag}, 32'd0);
        chk("reset_addr", bus.mem_address | bus.mem_write_data | bus.resp_rdata, 32'd0);
        @(negedge clk);
        mem_init = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        tv[0]  = '{1'b0, 3'b010, 32'h10,  32'h0,        5'd1,  1'b0, 32'hDEADBEEF, 2};
        tv[1]  = '{1'b1, 3'b000, 32'h13,  32'h80,       5'd2,  1'b0, 32'h0,        2};
        tv[2]  = '{1'b1, 3'b000, 32'h12,  32'hFFFFFF00, 5'd3,  1'b0, 32'h0,        2};
        tv[3]  = '{1'b0, 3'b000, 32'h13,  32'h0,        5'd4,  1'b0, 32'hFFFFFF80, 2};
        tv[4]  = '{1'b0, 3'b100, 32'h13,  32'h0,        5'd5,  1'b0, 32'h00000080, 2};
        tv[5]  = '{1'b0, 3'b001, 32'h12,  32'h0,        5'd6,  1'b0, 32'hFFFF8000, 2};
`ifdef MISALIGN_TRAP_EN
        tv[6]  = '{1'b1, 3'b010, 32'h21,  32'h11223344, 5'd7,  1'b1, 32'h0,        1};
        tv[7]  = '{1'b0, 3'b010, 32'h21,  32'h0,        5'd8,  1'b1, 32'h0,        1};
        tv[8]  = '{1'b0, 3'b101, 32'h11,  32'h0,        5'd9,  1'b1, 32'h0,        1};
`else
        tv[6]  = '{1'b1, 3'b010, 32'h21,  32'h11223344, 5'd7,  1'b0, 32'h0,        5};
        tv[7]  = '{1'b0, 3'b010, 32'h21,  32'h0,        5'd8,  1'b0, 32'h11223344, 5};
        tv[8]  = '{1'b0, 3'b101, 32'h11,  32'h0,        5'd9,  1'b0, 32'h000000BE, 3};
`endif
        tv[9]  = '{1'b0, 3'b010, 32'h3FE, 32'h0,        5'd10, 1'b1, 32'h0,        1};
        tv[10] = '{1'b0, 3'b000, 32'h3FF, 32'h0,        5'd11, 1'b0, 32'hFFFFFF9C, 2};
        tv[11] = '{1'b0, 3'b011, 32'h10,  32'h0,        5'd31, 1'b1, 32'h0,        1};
        tv[12] = '{1'b1, 3'b100, 32'h30,  32'h12345678, 5'd12, 1'b1, 32'h0,        1};
        tv[13] = '{1'b1, 3'b001, 32'h3FF, 32'h0000ABCD, 5'd13, 1'b1, 32'h0,        1};
        tv[14] = '{1'b1, 3'b001, 32'h30,  32'h7777A5B6, 5'd14, 1'b0, 32'h0,        2};
        tv[15] = '{1'b0, 3'b001, 32'h30,  32'h0,        5'd15, 1'b0, 32'hFFFFA5B6, 2};
        tv[16] = '{1'b0, 3'b101, 32'h30,  32'h0,        5'd16, 1'b0, 32'h0000A5B6, 2};

        for (int i = 0; i < 17; i++) begin
            do_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, tv[i].tag, g_err, g_rd, g_lat);
            chk($sformatf("tv%0d_err", i), 32'(g_err), 32'(tv[i].e_err));
            chk($sformatf("tv%0d_rdata", i), g_rd, tv[i].e_rdata);
            chk($sformatf("tv%0d_lat", i), 32'(g_lat), 32'(tv[i].e_lat));
        end

`ifndef MISALIGN_TRAP_EN
        // Reset arriving in the second beat of a split word store.
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h41; bus.req_wdata = 32'hAABBCCDD; bus.req_tag = 5'd20;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_beat0", bus.mem_address, 32'h41);
        @(negedge clk);
        chk("abort_beat1", bus.mem_address, 32'h42);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {20'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read,
                           bus.mem_write, bus.mem_size, bus.resp_tag}, 32'd0);
        chk("abort_data", bus.mem_address | bus.mem_write_data | bus.resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[65] = 8'hDD;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        g_lat = 0;
        repeat (4) begin
            if (bus.resp_valid) g_lat++;
            @(negedge clk);
        end
        chk("abort_no_resp", 32'(g_lat), 32'd0);
        chk("abort_byte0", 32'(mem[65]), 32'hDD);
        chk("abort_byte1", 32'(mem[66]), 32'h00);
`endif

        for (int i = 0; i < 300; i++) begin
            bit we;
            bit [2:0] f3;
            bit [31:0] addr;
            int r;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            addr = (r < 7) ? 32'($urandom_range(0, 255)) :
                   ((r < 9) ? 32'($urandom_range(1016, 1023)) : 32'($urandom));
            do_req(we, f3, addr, $urandom, 5'($urandom), g_err, g_rd, g_lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image_diffs", 32'(diffs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives the byte-addressed data memory's read/write/size/address/data lines. Memory writes on the clock edge; memory read data is combinational.
- Returns sign- or zero-extended load data, or store completion, to writeback.
- Misaligned accesses are split into sequential byte accesses.

Parameters:
- MEM_BYTES, 1024: memory size in bytes. Any access touching a byte at or above it is rejected.
- TAG_W, 5: width of the destination-register tag carried with each request.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  request rejected (illegal funct3, out of range, or trapped misalign)
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_tag  out  TAG_W  tag of the completed request
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_size  out  2  00 byte, 01 half, 10 word
- mem_address  out  32  memory byte address
- mem_write_data  out  32  memory write data
- mem_read_data  in  32  memory read data (combinational)

Behaviour:
- Reset is asynchronous. All outputs are 0 and state is IDLE while rst=1; req_ready=1 from the first clock after release.
- States:
  - IDLE: req_ready=1. Handshake on req_valid & req_ready at edge T latches the request.
  - ACCESS: drives the memory interface; byte counter idx.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- No response backpressure. At most one request is outstanding; req_ready=0 outside IDLE.
- mem_* are decoded from registered state only; there is no combinational path from req_* to mem_*. All mem_* are 0 outside ACCESS.
- Width N = 1/2/4 by funct3[1:0]. The access is misaligned if (N=2 and addr[0]) or (N=4 and addr[1:0]!=0).
- Error checks are decided at accept time:
  - Illegal funct3 (load 011/110/111, store with funct3[2]=1 or 011) → err.
  - Range is computed in 33 bits: addr+N-1 >= MEM_BYTES → err.
  - On err: go directly to DONE, resp at T+1, resp_err=1, rdata=0, no memory access.
- Aligned access: ACCESS for one cycle (T+1) with native mem_size and mem_address=addr.
  - Loads capture mem_read_data at the end of that cycle.
  - resp_valid at T+2.
- Misaligned access (macro off): ACCESS for N cycles, idx 0..N-1.
  - Each cycle: mem_size=00, mem_address=addr+idx.
  - Stores write byte req_wdata[8*idx+:8]; loads deposit the read byte into the assembly register lane idx.
  - resp_valid at T+1+N.
- Extension at response: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through. Store responses have rdata=0 and err=0.
- Memory-side read data from the word path is taken as-is; upper bytes for byte/half reads come from the extension logic, not from memory.
- Reset mid-operation: return to IDLE immediately. Store bytes already written stay written (no rollback). No response is issued for the aborted request.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: misaligned requests are rejected like errors — resp at T+1, resp_err=1, no memory access. The byte-split path and idx counter are not built.
- Undefined: misaligned requests are split into byte accesses as above.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - mem_size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10)
  - state typedef enum {IDLE, ACCESS, DONE}
- One sub-module, lsu_extend: combinational sign/zero extension of the 32-bit assembled data by funct3.

Test Plan:
- Memory[0x10..0x13]=EF,BE,AD,DE; LW 0x10 accepted at T → ACCESS T+1 with mem_size=10; resp T+2, rdata=0xDEADBEEF, err=0.
- Byte 0x80 at 0x13: LB 0x13 → rdata 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 (bytes 00,80) → 0xFFFF8000.
- Macro off, SW 0x11223344 to 0x21 → four mem_write cycles, bytes 44,33,22,11 at 0x21..0x24, resp T+5. A following LW 0x21 → rdata 0x11223344 at T+5.
- Macro on, same SW → resp T+1, err=1, mem_write never asserted, memory unchanged.
- MEM_BYTES=1024:
  - LW 0x3FE → err at T+1, no access.
  - LB 0x3FF → valid access.
  - Load funct3=011 → err, tag echoed.
- rst during idx=1 of a split SW → all outputs 0 asynchronously; only byte at addr+0 is written; after release req_ready=1 and no resp_valid.
